// File: rtl/id_ex_if.sv
// ID -> EX bundle for the ID/EX pipeline register.
//   id_* : decoded control bits, operands and register specifiers presented by ID
//   ex_* : registered copy of the id_* bundle, plus ex_valid (0 = bubble)
// Modports:
//   master : the decode side, which drives id_* and observes ex_*
//   slave  : the id_ex_stage, which samples id_* and drives ex_*
interface id_ex_if;
    logic        id_branch, id_reg_write, id_mem_read, id_mem_write;
    logic        id_alu_src_a, id_alu_src_b, id_lui_op;
    logic [1:0]  id_reg_dst, id_mem_to_reg, id_pc_source;
    logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [5:0]  id_opcode, id_funct;

    logic        ex_branch, ex_reg_write, ex_mem_read, ex_mem_write;
    logic        ex_alu_src_a, ex_alu_src_b, ex_lui_op;
    logic [1:0]  ex_reg_dst, ex_mem_to_reg, ex_pc_source;
    logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
    logic [5:0]  ex_opcode, ex_funct;
    logic        ex_valid;

    modport master (
        output id_branch, id_reg_write, id_mem_read, id_mem_write,
               id_alu_src_a, id_alu_src_b, id_lui_op,
               id_reg_dst, id_mem_to_reg, id_pc_source,
               id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext,
               id_rs, id_rt, id_rd, id_shamt, id_opcode, id_funct,
        input  ex_branch, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_alu_src_a, ex_alu_src_b, ex_lui_op,
               ex_reg_dst, ex_mem_to_reg, ex_pc_source,
               ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext,
               ex_rs, ex_rt, ex_rd, ex_shamt, ex_opcode, ex_funct, ex_valid
    );

    modport slave (
        input  id_branch, id_reg_write, id_mem_read, id_mem_write,
               id_alu_src_a, id_alu_src_b, id_lui_op,
               id_reg_dst, id_mem_to_reg, id_pc_source,
               id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext,
               id_rs, id_rt, id_rd, id_shamt, id_opcode, id_funct,
        output ex_branch, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_alu_src_a, ex_alu_src_b, ex_lui_op,
               ex_reg_dst, ex_mem_to_reg, ex_pc_source,
               ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext,
               ex_rs, ex_rt, ex_rd, ex_shamt, ex_opcode, ex_funct, ex_valid
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection for the 5-stage MIPS core.
// Ports:
//   clk, reset_n : rising-edge clock, asynchronous active-low reset
//   hold         : global freeze; every register keeps its value
//   flush_ex     : taken branch in EX; the ID instruction is replaced by a bubble
//   bus          : id_ex_if.slave, id_* in / ex_* + ex_valid out
//   stall_id     : combinational request to hold PC and IF/ID
//   stall_cnt    : saturating count of load-use bubbles inserted
//   flush_cnt    : saturating count of flushes applied
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             hold,
    input  logic             flush_ex,
    id_ex_if.slave           bus,
    output logic             stall_id,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef struct packed {
        logic        branch, reg_write, mem_read, mem_write;
        logic        alu_src_a, alu_src_b, lui_op;
        logic [1:0]  reg_dst, mem_to_reg, pc_source;
        logic [31:0] pc_plus4, rs_data, rt_data, imm_ext;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  opcode, funct;
    } ex_word_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ex_word_t         id_word, ex_q, ex_d;
    logic             ex_valid_q, ex_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             uses_rs, uses_rt, load_use;

    always_comb begin
        id_word.branch     = bus.id_branch;
        id_word.reg_write  = bus.id_reg_write;
        id_word.mem_read   = bus.id_mem_read;
        id_word.mem_write  = bus.id_mem_write;
        id_word.alu_src_a  = bus.id_alu_src_a;
        id_word.alu_src_b  = bus.id_alu_src_b;
        id_word.lui_op     = bus.id_lui_op;
        id_word.reg_dst    = bus.id_reg_dst;
        id_word.mem_to_reg = bus.id_mem_to_reg;
        id_word.pc_source  = bus.id_pc_source;
        id_word.pc_plus4   = bus.id_pc_plus4;
        id_word.rs_data    = bus.id_rs_data;
        id_word.rt_data    = bus.id_rt_data;
        id_word.imm_ext    = bus.id_imm_ext;
        id_word.rs         = bus.id_rs;
        id_word.rt         = bus.id_rt;
        id_word.rd         = bus.id_rd;
        id_word.shamt      = bus.id_shamt;
        id_word.opcode     = bus.id_opcode;
        id_word.funct      = bus.id_funct;
    end

    // Jumps, LUI and shift-by-shamt do not read rs; stores read rt even with an immediate.
    assign uses_rs  = (bus.id_pc_source != 2'b01) & ~bus.id_lui_op & ~bus.id_alu_src_a;
    assign uses_rt  = ~bus.id_alu_src_b | bus.id_mem_write;
    // A load writing $0 produces nothing to wait for.
    assign load_use = ex_valid_q & ex_q.mem_read & (ex_q.rt != 5'd0) &
                      ((uses_rs & (ex_q.rt == bus.id_rs)) |
                       (uses_rt & (ex_q.rt == bus.id_rt)));
    // A flush discards the ID instruction, so there is nothing left to hold for.
    assign stall_id = hold | (load_use & ~flush_ex);

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        ex_d        = ex_q;
        ex_valid_d  = ex_valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!hold) begin
            if (flush_ex) begin
                ex_d        = '0;
                ex_valid_d  = 1'b0;
                flush_cnt_d = (flush_cnt_q == '1) ? flush_cnt_q : flush_cnt_q + CNT_ONE;
            end else if (load_use) begin
                // ID is frozen by stall_id; the bubble's mem_read=0 lets it pass next cycle.
                ex_d        = '0;
                ex_valid_d  = 1'b0;
                stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + CNT_ONE;
            end else begin
                ex_d        = id_word;
                ex_valid_d  = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q        <= '0;
            ex_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            ex_valid_q  <= ex_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.ex_branch     = ex_q.branch;
    assign bus.ex_reg_write  = ex_q.reg_write;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_write  = ex_q.mem_write;
    assign bus.ex_alu_src_a  = ex_q.alu_src_a;
    assign bus.ex_alu_src_b  = ex_q.alu_src_b;
    assign bus.ex_lui_op     = ex_q.lui_op;
    assign bus.ex_reg_dst    = ex_q.reg_dst;
    assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
    assign bus.ex_pc_source  = ex_q.pc_source;
    assign bus.ex_pc_plus4   = ex_q.pc_plus4;
    assign bus.ex_rs_data    = ex_q.rs_data;
    assign bus.ex_rt_data    = ex_q.rt_data;
    assign bus.ex_imm_ext    = ex_q.imm_ext;
    assign bus.ex_rs         = ex_q.rs;
    assign bus.ex_rt         = ex_q.rt;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_shamt      = ex_q.shamt;
    assign bus.ex_opcode     = ex_q.opcode;
    assign bus.ex_funct      = ex_q.funct;
    assign bus.ex_valid      = ex_valid_q;
    assign stall_cnt         = stall_cnt_q;
    assign flush_cnt         = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage (CNT_W=4 so counter saturation is reachable).
module tb_id_ex_stage;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        branch, reg_write, mem_read, mem_write;
        logic        alu_src_a, alu_src_b, lui_op;
        logic [1:0]  reg_dst, mem_to_reg, pc_source;
        logic [31:0] pc_plus4, rs_data, rt_data, imm_ext;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  opcode, funct;
    } instr_t;

    typedef struct {
        instr_t     id;
        logic       hold;
        logic       flush;
        logic       exp_stall;
        logic       exp_valid;
        logic [4:0] exp_rd;
        int         exp_scnt;
        int         exp_fcnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic hold = 1'b0;
    logic flush_ex = 1'b0;
    logic stall_id;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    id_ex_if bus();

    id_ex_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .hold(hold), .flush_ex(flush_ex),
        .bus(bus), .stall_id(stall_id), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what EX should hold, from the stage's rules.
    instr_t m_ex;
    logic   m_valid;
    int     m_scnt, m_fcnt;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- instruction builders ----------------
    function automatic instr_t base();
        instr_t i = '0;
        i.pc_plus4 = $urandom;
        i.rs_data  = $urandom;
        i.rt_data  = $urandom;
        i.imm_ext  = $urandom;
        return i;
    endfunction

    function automatic instr_t mk_add(input logic [4:0] rd, rs, rt);
        instr_t i = base();
        i.reg_write = 1'b1; i.reg_dst = 2'b01;
        i.rs = rs; i.rt = rt; i.rd = rd; i.opcode = 6'h00; i.funct = 6'h20;
        return i;
    endfunction

    function automatic instr_t mk_sll(input logic [4:0] rd, rt, sh);
        instr_t i = base();
        i.reg_write = 1'b1; i.reg_dst = 2'b01; i.alu_src_a = 1'b1;
        i.rt = rt; i.rd = rd; i.shamt = sh; i.opcode = 6'h00; i.funct = 6'h00;
        return i;
    endfunction

    function automatic instr_t mk_lw(input logic [4:0] rt, rs);
        instr_t i = base();
        i.reg_write = 1'b1; i.mem_read = 1'b1; i.alu_src_b = 1'b1; i.mem_to_reg = 2'b01;
        i.rs = rs; i.rt = rt; i.opcode = 6'h23;
        return i;
    endfunction

    function automatic instr_t mk_sw(input logic [4:0] rt, rs);
        instr_t i = base();
        i.mem_write = 1'b1; i.alu_src_b = 1'b1;
        i.rs = rs; i.rt = rt; i.opcode = 6'h2b;
        return i;
    endfunction

    function automatic instr_t mk_j();
        instr_t i = base();
        i.pc_source = 2'b01; i.alu_src_b = 1'b1;
        i.rs = 5'd8; i.rt = 5'd8; i.opcode = 6'h02;
        return i;
    endfunction

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd2;
            default: return 5'd8;
        endcase
    endfunction

    function automatic instr_t rand_instr();
        case ($urandom_range(0, 4))
            0: return mk_add(pick_reg(), pick_reg(), pick_reg());
            1: return mk_sll(pick_reg(), pick_reg(), 5'($urandom_range(0, 31)));
            2: return mk_lw(pick_reg(), pick_reg());
            3: return mk_sw(pick_reg(), pick_reg());
            default: return mk_j();
        endcase
    endfunction

    // ---------------- reference model ----------------
    // An instruction reads rs unless it is a jump, LUI or shift-by-shamt;
    // it reads rt when the ALU B operand is a register or when it stores rt.
    function automatic logic reads_rs(input instr_t i);
        return (i.pc_source != 2'b01) && !i.lui_op && !i.alu_src_a;
    endfunction

    function automatic logic reads_rt(input instr_t i);
        return !i.alu_src_b || i.mem_write;
    endfunction

    function automatic logic model_load_use(input instr_t id);
        if (!(m_valid && m_ex.mem_read) || m_ex.rt == 5'd0) return 1'b0;
        return (reads_rs(id) && id.rs == m_ex.rt) || (reads_rt(id) && id.rt == m_ex.rt);
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= CNT_MAX) ? CNT_MAX : c + 1;
    endfunction

    task automatic model_reset();
        m_ex = '0; m_valid = 1'b0; m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic model_step(input instr_t id, input logic h, input logic f);
        if (h) return;
        if (f) begin
            m_ex = '0; m_valid = 1'b0; m_fcnt = sat_inc(m_fcnt);
        end else if (model_load_use(id)) begin
            m_ex = '0; m_valid = 1'b0; m_scnt = sat_inc(m_scnt);
        end else begin
            m_ex = id; m_valid = 1'b1;
        end
    endtask

    // ---------------- DUT access ----------------
    function automatic instr_t dut_ex();
        instr_t i;
        i.branch = bus.ex_branch;         i.reg_write = bus.ex_reg_write;
        i.mem_read = bus.ex_mem_read;     i.mem_write = bus.ex_mem_write;
        i.alu_src_a = bus.ex_alu_src_a;   i.alu_src_b = bus.ex_alu_src_b;
        i.lui_op = bus.ex_lui_op;         i.reg_dst = bus.ex_reg_dst;
        i.mem_to_reg = bus.ex_mem_to_reg; i.pc_source = bus.ex_pc_source;
        i.pc_plus4 = bus.ex_pc_plus4;     i.rs_data = bus.ex_rs_data;
        i.rt_data = bus.ex_rt_data;       i.imm_ext = bus.ex_imm_ext;
        i.rs = bus.ex_rs; i.rt = bus.ex_rt; i.rd = bus.ex_rd; i.shamt = bus.ex_shamt;
        i.opcode = bus.ex_opcode;         i.funct = bus.ex_funct;
        return i;
    endfunction

    task automatic drive(input instr_t i, input logic h, input logic f);
        hold = h; flush_ex = f;
        bus.id_branch = i.branch;         bus.id_reg_write = i.reg_write;
        bus.id_mem_read = i.mem_read;     bus.id_mem_write = i.mem_write;
        bus.id_alu_src_a = i.alu_src_a;   bus.id_alu_src_b = i.alu_src_b;
        bus.id_lui_op = i.lui_op;         bus.id_reg_dst = i.reg_dst;
        bus.id_mem_to_reg = i.mem_to_reg; bus.id_pc_source = i.pc_source;
        bus.id_pc_plus4 = i.pc_plus4;     bus.id_rs_data = i.rs_data;
        bus.id_rt_data = i.rt_data;       bus.id_imm_ext = i.imm_ext;
        bus.id_rs = i.rs; bus.id_rt = i.rt; bus.id_rd = i.rd; bus.id_shamt = i.shamt;
        bus.id_opcode = i.opcode;         bus.id_funct = i.funct;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".ex_word"}, 256'(dut_ex()), 256'(m_ex));
        check({tag, ".ex_valid"}, 256'(bus.ex_valid), 256'(m_valid));
        check({tag, ".stall_cnt"}, 256'(stall_cnt), 256'(m_scnt));
        check({tag, ".flush_cnt"}, 256'(flush_cnt), 256'(m_fcnt));
    endtask

    // One cycle: drive just after a rising edge, check stall_id on the falling
    // edge, then check the registered state 1 time unit after the next rising edge.
    task automatic cycle(input string tag, input instr_t id, input logic h, input logic f);
        logic exp_stall;
        drive(id, h, f);
        @(negedge clk);
        exp_stall = h | (model_load_use(id) & ~f);
        check({tag, ".stall_id"}, 256'(stall_id), 256'(exp_stall));
        @(posedge clk);
        model_step(id, h, f);
        #1;
        check_state(tag);
    endtask

    vec_t tbl[19];

    initial begin
        instr_t add981, lw8, sll, swi;
        add981 = mk_add(5'd9, 5'd8, 5'd1);
        lw8    = mk_lw(5'd8, 5'd2);
        sll    = mk_sll(5'd9, 5'd8, 5'd2);
        swi    = mk_sw(5'd5, 5'd3);

        //           id                         h     f     stall valid rd    scnt fcnt
        tbl[0]  = '{add981,                    1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 0, 0};
        tbl[1]  = '{lw8,                       1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 0, 0};
        tbl[2]  = '{add981,                    1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1, 0};
        tbl[3]  = '{add981,                    1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1, 0};
        tbl[4]  = '{mk_lw(5'd0, 5'd2),         1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1, 0};
        tbl[5]  = '{mk_add(5'd9, 5'd0, 5'd0),  1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1, 0};
        tbl[6]  = '{lw8,                       1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1, 0};
        tbl[7]  = '{sll,                       1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 2, 0};
        tbl[8]  = '{sll,                       1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 2, 0};
        tbl[9]  = '{lw8,                       1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 2, 0};
        tbl[10] = '{mk_j(),                    1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 2, 0};
        tbl[11] = '{lw8,                       1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 2, 0};
        tbl[12] = '{add981,                    1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2, 1};
        tbl[13] = '{lw8,                       1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 2, 1};
        tbl[14] = '{swi,                       1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 2, 1};
        tbl[15] = '{add981,                    1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 2, 1};
        tbl[16] = '{add981,                    1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 2, 1};
        tbl[17] = '{add981,                    1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 2, 1};
        tbl[18] = '{add981,                    1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 2, 1};

        // Reset state
        model_reset();
        drive('0, 1'b0, 1'b0);
        #2;
        check_state("reset");
        #10 reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed table: pass-through, load-use, $0, sll/j, flush+hazard, hold
        for (int k = 0; k < 19; k++) begin
            logic exp_stall;
            drive(tbl[k].id, tbl[k].hold, tbl[k].flush);
            @(negedge clk);
            exp_stall = tbl[k].hold | (model_load_use(tbl[k].id) & ~tbl[k].flush);
            check($sformatf("tbl%0d.stall_id", k), 256'(stall_id), 256'(tbl[k].exp_stall));
            check($sformatf("tbl%0d.stall_model", k), 256'(stall_id), 256'(exp_stall));
            @(posedge clk);
            model_step(tbl[k].id, tbl[k].hold, tbl[k].flush);
            #1;
            check($sformatf("tbl%0d.ex_valid", k), 256'(bus.ex_valid), 256'(tbl[k].exp_valid));
            check($sformatf("tbl%0d.ex_rd", k), 256'(bus.ex_rd), 256'(tbl[k].exp_rd));
            check($sformatf("tbl%0d.stall_cnt", k), 256'(stall_cnt), 256'(tbl[k].exp_scnt));
            check($sformatf("tbl%0d.flush_cnt", k), 256'(flush_cnt), 256'(tbl[k].exp_fcnt));
            check_state($sformatf("tbl%0d", k));
        end

        // Stall counter saturation: 20 load-use events
        for (int k = 0; k < 20; k++) begin
            cycle("sat_lw", lw8, 1'b0, 1'b0);
            cycle("sat_stall", add981, 1'b0, 1'b0);
            cycle("sat_pass", add981, 1'b0, 1'b0);
        end
        check("stall_cnt_saturated", 256'(stall_cnt), 256'(CNT_MAX));

        // Flush counter saturation
        for (int k = 0; k < 20; k++) cycle("sat_flush", rand_instr(), 1'b0, 1'b1);
        check("flush_cnt_saturated", 256'(flush_cnt), 256'(CNT_MAX));

        // Asynchronous reset mid-stream with a valid instruction in EX
        cycle("pre_reset", add981, 1'b0, 1'b0);
        check("pre_reset.valid", 256'(bus.ex_valid), 256'(1'b1));
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check_state("async_reset");
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic against the model
        for (int k = 0; k < 2000; k++) begin
            cycle("rand", rand_instr(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
